// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the data memory controller
package mem_pkg;

  // Access size encoding as carried on req_size
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Controller states: waiting for a request, counting latency, presenting a response
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // Number of bytes touched by an access; illegal size reports 4 but is always flagged as an error
  function automatic logic [2:0] size_bytes(input size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_load_extend.sv
// rtl/data_mem_ctrl_load_extend.sv - sign/zero extension of little-endian load bytes
module load_extend
  import mem_pkg::*;
(
  input  size_e       size,
  input  logic        uns,
  input  logic [31:0] raw,
  output logic [31:0] ext
);

  // Replicate the top loaded bit (or zero when unsigned) into the unused upper bits
  always_comb begin
    ext = '0;
    case (size)
      SZ_BYTE: ext = {{24{~uns & raw[7]}}, raw[7:0]};
      SZ_HALF: ext = {{16{~uns & raw[15]}}, raw[15:0]};
      SZ_WORD: ext = raw;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - byte-addressed data memory with request/response handshakes
module data_mem_ctrl
  import mem_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32,
  parameter int READ_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int CW = $clog2(READ_LAT + 1);

  logic [7:0] mem [0:MEM_BYTES-1];

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            resp_valid_q, resp_valid_d;
  logic [31:0]     resp_rdata_q, resp_rdata_d;
  logic            resp_err_q, resp_err_d;

  size_e           req_sz;
  logic [AW-1:0]   idx;
  logic [ADDR_W:0] end_addr;
  logic            misaligned;
  logic            out_of_range;
  logic            acc_err;
  logic            accept;
  logic [31:0]     raw_word;
  logic [31:0]     ext_word;

  assign req_sz    = size_e'(req_size);
  assign idx       = req_addr[AW-1:0];
  assign req_ready = (state_q == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Last byte address is computed one bit wider so high address bits and carry both count as out of range
  assign end_addr     = {1'b0, req_addr} + (ADDR_W+1)'(size_bytes(req_sz)) - (ADDR_W+1)'(1);
  assign out_of_range = end_addr >= (ADDR_W+1)'(MEM_BYTES);
  assign misaligned   = ((req_sz == SZ_HALF) && req_addr[0]) ||
                        ((req_sz == SZ_WORD) && (req_addr[1:0] != 2'b00));
  assign acc_err      = (req_sz == SZ_ILL) || misaligned || out_of_range;

  // Four consecutive bytes at the request address; index wrap only matters for erroring accesses
  assign raw_word = {mem[idx + AW'(3)], mem[idx + AW'(2)], mem[idx + AW'(1)], mem[idx]};

  load_extend u_load_extend (
    .size (req_sz),
    .uns  (req_unsigned),
    .raw  (raw_word),
    .ext  (ext_word)
  );

  // Store commits at the accept edge; storage has no reset so data survives rst
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(size_bytes(req_sz))) begin
          mem[idx + AW'(k)] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  // Next-state: capture the result at accept, count latency, release on response handshake
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d      = WAIT;
          cnt_d        = CW'(READ_LAT - 1);
          resp_err_d   = acc_err;
          resp_rdata_d = (acc_err || req_we) ? 32'h0 : ext_word;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  // Controller state and registered response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;

  localparam int MEM = 1024;
  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] model_mem [0:MEM-1];

  data_mem_ctrl #(.MEM_BYTES(MEM), .ADDR_W(32), .READ_LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference behaviour: plain byte array, little-endian assembly, arithmetic extension
  task automatic model(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int     nb;
    int     base;
    longint last;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    last = longint'(addr) + longint'(nb) - 1;
    er   = (sz == 2'd3) || (sz == 2'd1 && addr[0]) || (sz == 2'd2 && addr[1:0] != 2'b00) || (last >= MEM);
    rd   = 32'h0;
    if (!er) begin
      base = int'(addr[9:0]);
      if (we) begin
        for (int k = 0; k < nb; k++) model_mem[base + k] = wd[8*k +: 8];
      end else begin
        v = 32'h0;
        for (int k = 0; k < nb; k++) v = v | (32'(model_mem[base + k]) << (8 * k));
        if (!uns && model_mem[base + nb - 1][7]) v = v | (32'hFFFF_FFFF << (8 * nb));
        rd = v;
      end
    end
  endtask

  task automatic scramble_req();
    req_valid    = 1'($urandom);
    req_we       = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // One request/response through the DUT; called at posedge+1, returns at posedge+1
  task automatic access(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
    int n;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("req_ready_busy", 32'(req_ready), 32'd0);
    n = 0;
    do begin
      scramble_req();
      resp_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end while (!resp_valid && n < LAT + 10);
    check_eq("latency", 32'(n), 32'(LAT));
    resp_ready = 1'b0;
    rd = resp_rdata;
    er = resp_err;
    for (int h = 0; h < hold; h++) begin
      scramble_req();
      @(posedge clk); #1;
      check_eq("hold_valid", 32'(resp_valid), 32'd1);
      check_eq("hold_rdata", resp_rdata, rd);
      check_eq("hold_err", 32'(resp_err), 32'(er));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    check_eq("post_valid", 32'(resp_valid), 32'd0);
    check_eq("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic run(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] addr,
                     input logic [31:0] wd, input int hold, output logic [31:0] rd, output logic er);
    logic [31:0] exp_rd;
    bit          exp_er;
    model(we, sz, uns, addr, wd, exp_rd, exp_er);
    access(we, sz, uns, addr, wd, hold, rd, er);
    check_eq($sformatf("rdata@%08h", addr), rd, exp_rd);
    check_eq($sformatf("err@%08h", addr), 32'(er), 32'(exp_er));
  endtask

  logic [31:0] rd;
  logic        er;
  logic [31:0] exp_rd;
  bit          exp_er;
  logic [31:0] a;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'h0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("req_ready_after_rst", 32'(req_ready), 32'd1);

    // Fill storage so every later load has a known image
    for (int w = 0; w < MEM / 4; w++) run(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 0, rd, er);

    // Word store / load and little-endian byte order
    run(1'b1, 2'd2, 1'b0, 32'h10, 32'h80FF7F01, 0, rd, er);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
    check_eq("t2_word", rd, 32'h80FF7F01);
    run(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 0, rd, er); check_eq("t2_b0", rd, 32'h01);
    run(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 0, rd, er); check_eq("t2_b1", rd, 32'h7F);
    run(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0, rd, er); check_eq("t2_b2", rd, 32'hFF);
    run(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, rd, er); check_eq("t2_b3", rd, 32'h80);

    // Extension
    run(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0, rd, er); check_eq("t3_sb", rd, 32'hFFFFFFFF);
    run(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0, rd, er); check_eq("t3_ub", rd, 32'h000000FF);
    run(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, rd, er); check_eq("t3_sh", rd, 32'hFFFF80FF);
    run(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 0, rd, er); check_eq("t3_uh", rd, 32'h000080FF);

    // Partial stores leave neighbouring bytes alone
    run(1'b1, 2'd0, 1'b0, 32'h11, 32'h55AA, 0, rd, er);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er); check_eq("t4_byte", rd, 32'h80FFAA01);
    run(1'b1, 2'd1, 1'b0, 32'h12, 32'hDEAD1234, 0, rd, er);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er); check_eq("t4_half", rd, 32'h1234AA01);

    // Error cases
    run(1'b1, 2'd2, 1'b0, 32'h11, 32'hFFFFFFFF, 0, rd, er);
    check_eq("t5_ws11_err", 32'(er), 32'd1); check_eq("t5_ws11_rd", rd, 32'h0);
    run(1'b0, 2'd1, 1'b0, 32'h3, 32'h0, 0, rd, er);
    check_eq("t5_hl3_err", 32'(er), 32'd1); check_eq("t5_hl3_rd", rd, 32'h0);
    run(1'b0, 2'd3, 1'b0, 32'h20, 32'h0, 0, rd, er);
    check_eq("t5_ill_err", 32'(er), 32'd1); check_eq("t5_ill_rd", rd, 32'h0);
    run(1'b0, 2'd2, 1'b0, 32'h3FE, 32'h0, 0, rd, er);
    check_eq("t5_3fe_err", 32'(er), 32'd1); check_eq("t5_3fe_rd", rd, 32'h0);
    run(1'b0, 2'd0, 1'b0, 32'h400, 32'h0, 0, rd, er);
    check_eq("t5_400_err", 32'(er), 32'd1); check_eq("t5_400_rd", rd, 32'h0);
    run(1'b1, 2'd0, 1'b0, 32'h8000_0010, 32'h77, 0, rd, er);
    check_eq("t5_hi_err", 32'(er), 32'd1);
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er); check_eq("t5_unchanged", rd, 32'h1234AA01);
    run(1'b0, 2'd1, 1'b1, 32'h3FE, 32'h0, 0, rd, er); check_eq("t5_last_half_err", 32'(er), 32'd0);

    // Response held for several cycles
    run(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4, rd, er); check_eq("t6_hold", rd, 32'h1234AA01);

    // Reset during WAIT: response dropped, accepted store kept
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    model(1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, exp_rd, exp_er);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("t6_rst_valid", 32'(resp_valid), 32'd0);
    check_eq("t6_rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("t6_ready_after_rst", 32'(req_ready), 32'd1);
    for (int c = 0; c < LAT + 2; c++) begin
      @(posedge clk); #1;
      check_eq("t6_no_resp", 32'(resp_valid), 32'd0);
    end
    run(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 0, rd, er); check_eq("t6_store_kept", rd, 32'hCAFEF00D);

    // Randomized traffic against the reference model
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0:       a = 32'(MEM) + $urandom_range(0, 64);
        1:       a = $urandom;
        default: a = 32'($urandom_range(0, MEM - 1));
      endcase
      if ($urandom_range(0, 3) != 0) a = a & 32'hFFFF_FFFC;
      run(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, $urandom_range(0, 3), rd, er);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
